// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating multiply-accumulate back end.
// Takes 16-bit unsigned products from the array multiplier's product
// register and sums a programmed number of them into an ACC_W-bit
// saturating accumulator. The result is presented with a valid/ready
// handshake.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start, len   begin a job of len products (sampled only in IDLE)
//   prod_in      unsigned product term
//   prod_valid   prod_in is a valid term this cycle (ignored outside ACCUM)
//   acc_out      registered accumulated sum
//   acc_valid    acc_out holds a completed result (HOLD state)
//   out_ready    consumer accepts the result
//   busy         state is not IDLE
//   ovf          sticky saturation flag for the current or last job
module mac_accumulator #(
  parameter int ACC_W = 20,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      prod_in,
  input  logic             prod_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W:0]   sum;
  logic             take;
  logic             launch;

  // One extra bit catches the carry out; a set carry means saturate.
  assign sum    = (ACC_W+1)'(acc_out) + (ACC_W+1)'(prod_in);
  assign take   = (state == ACCUM) && prod_valid;
  assign launch = (state == IDLE) && start;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (take && (cnt == LEN_W'(1))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (launch) begin
      acc_out <= '0;
      cnt     <= len;
      ovf     <= 1'b0;
    end else if (take) begin
      if (sum[ACC_W]) begin
        acc_out <= '1;
        ovf     <= 1'b1;
      end else begin
        acc_out <= sum[ACC_W-1:0];
      end
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed and randomized jobs against a reference
// model that computes each job's expected result as min(total, max) with
// ovf = (total > max); this equals sticky saturation for unsigned adds.
module tb_mac_accumulator;

  localparam int ACC_W = 20;
  localparam int LEN_W = 8;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      prod_in;
  logic             prod_valid;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] terms[$];

  mac_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job over the queued terms, with up to gap_max stall cycles
  // before each term, hold_cyc cycles of backpressure, and optional stray
  // start/prod_valid pulses while the result is held.
  task automatic run_job(input int unsigned gap_max, input int unsigned hold_cyc,
                         input bit stray);
    longint total = 0;
    logic [31:0] exp_acc;
    logic [31:0] exp_ovf;
    int unsigned l = terms.size();
    foreach (terms[i]) total += longint'(terms[i]);
    exp_acc = (total > ACC_MAX) ? 32'(ACC_MAX) : 32'(total);
    exp_ovf = (total > ACC_MAX) ? 32'd1 : 32'd0;

    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    chk("acc_cleared", 32'(acc_out), (l == 0) ? 32'd0 : 32'd0);
    chk("ovf_cleared", 32'(ovf), 0);
    if (l != 0) chk("no_valid_accum", 32'(acc_valid), 0);

    for (int unsigned i = 0; i < l; i++) begin
      int unsigned gaps = $urandom_range(gap_max, 0);
      for (int unsigned g = 0; g < gaps; g++) begin
        prod_valid = 1'b0;
        prod_in    = 16'($urandom);
        tick();
        chk("stall_no_valid", 32'(acc_valid), 0);
      end
      prod_valid = 1'b1;
      prod_in    = terms[i];
      tick();
      prod_valid = 1'b0;
      prod_in    = 16'($urandom);
      if (i + 1 < l) chk("early_valid", 32'(acc_valid), 0);
    end

    chk("hold_valid", 32'(acc_valid), 1);
    chk("hold_acc", 32'(acc_out), exp_acc);
    chk("hold_ovf", 32'(ovf), exp_ovf);
    for (int unsigned c = 0; c < hold_cyc; c++) begin
      out_ready  = 1'b0;
      start      = stray;
      len        = LEN_W'($urandom_range(9, 1));
      prod_valid = stray;
      prod_in    = 16'($urandom);
      tick();
      start      = 1'b0;
      prod_valid = 1'b0;
      chk("bp_valid", 32'(acc_valid), 1);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_acc", 32'(acc_out), exp_acc);
      chk("bp_ovf", 32'(ovf), exp_ovf);
    end

    // Handshake; a start in the same cycle must be ignored.
    out_ready = 1'b1;
    start     = stray;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("post_hs_valid", 32'(acc_valid), 0);
    chk("post_hs_busy", 32'(busy), 0);
    chk("post_hs_acc", 32'(acc_out), exp_acc);
    chk("post_hs_ovf", 32'(ovf), exp_ovf);

    // A stray product in IDLE does not touch the result.
    prod_valid = 1'b1;
    prod_in    = 16'($urandom);
    tick();
    prod_valid = 1'b0;
    chk("idle_acc_kept", 32'(acc_out), exp_acc);
    chk("idle_busy", 32'(busy), 0);
    terms.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    #2;
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_valid", 32'(acc_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy0", 32'(busy), 0);
    chk("idle_valid0", 32'(acc_valid), 0);

    // Reset in the middle of an accumulation.
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1;
      prod_in    = 16'h1234;
      tick();
    end
    prod_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_acc", 32'(acc_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(acc_valid), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_rst_valid", 32'(acc_valid), 0);
      chk("after_rst_busy", 32'(busy), 0);
    end

    // Back-to-back 1..4.
    terms = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_job(0, 0, 1'b0);
    // Stalled 100,200,300.
    terms = '{16'd100, 16'd200, 16'd300};
    run_job(2, 0, 1'b0);
    // Saturation with 17 x 0xFE01, then a clean job.
    for (int i = 0; i < 17; i++) terms.push_back(16'hFE01);
    run_job(0, 1, 1'b0);
    terms = '{16'd5};
    run_job(0, 0, 1'b0);
    // Backpressure with stray start/prod_valid in HOLD.
    terms = '{16'd7, 16'd9};
    run_job(0, 5, 1'b1);
    // Zero-length job.
    run_job(0, 0, 1'b0);
    // Products of 3*4 and 5*6 as delivered by the multiplier.
    terms = '{16'(3 * 4), 16'(5 * 6)};
    run_job(1, 0, 1'b0);

    // Randomized jobs; some with large products to provoke saturation.
    for (int j = 0; j < 40; j++) begin
      int unsigned l   = $urandom_range(20, 0);
      bit          big = ($urandom_range(2, 0) == 0);
      for (int unsigned i = 0; i < l; i++) begin
        terms.push_back(big ? (16'hF000 | 16'($urandom_range(16'h0FFF, 0)))
                            : 16'($urandom));
      end
      run_job($urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
